not_gate_unit: RTL and testbench

Parameterized inverter stage that provides a purely combinational bitwise NOT output and a registered, valid-qualified NOT output. It is the basic logic-level primitive of the CPU datapath. Downstream blocks use the combinational path for zero-latency logic and the registered path where a pipeline boundary is required. An optional toggle counter can be compiled in for activity monitoring.

---
 rtl/not_gate_unit.sv | 66 ++++++
 tb/tb_not_gate_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/not_gate_unit.sv
// Parameterized inverter: combinational ~in plus a registered, valid-qualified ~in.
// Define NOT_GATE_STATS_EN to add a saturating toggle counter on the registered output.
module not_gate_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
`ifdef NOT_GATE_STATS_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);

  // Handshake: in_valid qualifies in on a rising edge and is always accepted
  // (no ready). out_valid pulses for exactly the one cycle after each accept.

  generate
    if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad_param
      $error("not_gate_unit: illegal WIDTH or CNT_W");
    end
  endgenerate

  logic [WIDTH-1:0] inv;

  assign inv = ~in;
  assign out = inv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= inv;
      end
    end
  end

`ifdef NOT_GATE_STATS_EN
  logic cnt_inc;

  // Count only accepted values that actually change out_q; hold at all-ones.
  always_comb begin
    cnt_inc = 1'b0;
    if (in_valid && (inv != out_q) && (toggle_cnt != {CNT_W{1'b1}})) begin
      cnt_inc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      toggle_cnt <= '0;
    end else if (cnt_inc) begin
      toggle_cnt <= toggle_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_not_gate_unit.sv
// Directed bench for not_gate_unit: combinational path, reset, latency, streaming,
// reset priority and (with NOT_GATE_STATS_EN) the saturating toggle counter.
module tb_not_gate_unit;

  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in;
  logic          in_valid;
  logic [W-1:0]  out;
  logic [W-1:0]  out_q;
  logic          out_valid;
`ifdef NOT_GATE_STATS_EN
  logic [CW-1:0] toggle_cnt;
`endif

  logic [0:0] in1;
  logic [0:0] out1;
  logic [0:0] out_q1;
  logic       out_valid1;
`ifdef NOT_GATE_STATS_EN
  logic [CW-1:0] toggle_cnt1;
`endif

  int n_cmp;
  int n_bad;

  not_gate_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid)
`ifdef NOT_GATE_STATS_EN
    ,
    .toggle_cnt(toggle_cnt)
`endif
  );

  not_gate_unit #(.WIDTH(1), .CNT_W(CW)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in1),
    .in_valid  (1'b0),
    .out       (out1),
    .out_q     (out_q1),
    .out_valid (out_valid1)
`ifdef NOT_GATE_STATS_EN
    ,
    .toggle_cnt(toggle_cnt1)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one active edge, then settle on the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_comb();
    rst_n = 1'b0;
    in1   = 1'b1;
    #1;
    n_cmp++;
    if (out1 !== 1'b0) begin
      n_bad++;
      $display("FAIL comb_in1: got %b want 0", out1);
    end
    #10;
    in1   = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (out1 !== 1'b1) begin
      n_bad++;
      $display("FAIL comb_in0: got %b want 1", out1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in       = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (out_q !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_out_q[%0d]: got %h want 00", i, out_q);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid);
      end
      n_cmp++;
      if (out !== 8'h5A) begin
        n_bad++;
        $display("FAIL reset_comb[%0d]: got %h want 5a", i, out);
      end
`ifdef NOT_GATE_STATS_EN
      n_cmp++;
      if (toggle_cnt !== 2'd0) begin
        n_bad++;
        $display("FAIL reset_cnt[%0d]: got %0d want 0", i, toggle_cnt);
      end
`endif
    end
  endtask

  task automatic test_latency();
    rst_n    = 1'b1;
    in       = 8'h0F;
    in_valid = 1'b1;
    step();
    n_cmp++;
    if (out_q !== 8'hF0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_first: got out_q=%h v=%b want f0 1", out_q, out_valid);
    end
    in_valid = 1'b0;
    in       = 8'h77;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_pulse: got v=%b want 0", out_valid);
    end
    n_cmp++;
    if (out_q !== 8'hF0) begin
      n_bad++;
      $display("FAIL latency_hold: got %h want f0", out_q);
    end
    n_cmp++;
    if (out !== 8'h88) begin
      n_bad++;
      $display("FAIL latency_comb: got %h want 88", out);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] stim [3];
    logic [W-1:0] want [3];
    stim = '{8'h00, 8'hFF, 8'h3C};
    want = '{8'hFF, 8'h00, 8'hC3};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in = stim[i];
      step();
      n_cmp++;
      if (out_q !== want[i]) begin
        n_bad++;
        $display("FAIL stream_out_q[%0d]: got %h want %h", i, out_q, want[i]);
      end
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || out_q !== 8'hC3) begin
      n_bad++;
      $display("FAIL stream_end: got q=%h v=%b want c3 0", out_q, out_valid);
    end
  endtask

  task automatic test_reset_priority();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in       = 8'h01;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rstpri_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_q !== 8'h00) begin
      n_bad++;
      $display("FAIL rstpri_out_q: got %h want 00", out_q);
    end
    // First edge with rst_n high must accept.
    rst_n = 1'b1;
    in    = 8'h12;
    step();
    n_cmp++;
    if (out_q !== 8'hED || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstpri_release: got q=%h v=%b want ed 1", out_q, out_valid);
    end
    in_valid = 1'b0;
  endtask

`ifdef NOT_GATE_STATS_EN
  task automatic test_stats();
    logic [W-1:0]  stim [5];
    logic [CW-1:0] want [5];
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    stim = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in = stim[i];
      step();
      n_cmp++;
      if (toggle_cnt !== want[i]) begin
        n_bad++;
        $display("FAIL stats_cnt[%0d]: got %0d want %0d", i, toggle_cnt, want[i]);
      end
    end
    in = 8'h00;
    step();
    n_cmp++;
    if (toggle_cnt !== 2'd3 || out_valid !== 1'b1 || out_q !== 8'hFF) begin
      n_bad++;
      $display("FAIL stats_repeat: got cnt=%0d v=%b q=%h want 3 1 ff",
               toggle_cnt, out_valid, out_q);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stats_nochange();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in       = 8'hFF;
    step();
    n_cmp++;
    if (toggle_cnt !== 2'd0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stats_same_as_reset: got cnt=%0d v=%b want 0 1", toggle_cnt, out_valid);
    end
    in_valid = 1'b0;
    in       = 8'h00;
    step();
    n_cmp++;
    if (toggle_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL stats_invalid: got cnt=%0d want 0", toggle_cnt);
    end
  endtask
`endif

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    in       = '0;
    in_valid = 1'b0;
    in1      = 1'b0;
    test_comb();
    test_reset();
    test_latency();
    test_back_to_back();
    test_reset_priority();
`ifdef NOT_GATE_STATS_EN
    test_stats();
    test_stats_nochange();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
